serial_add_ctrl: RTL and testbench

- Sequencing controller for one external 1-bit full adder.
- Captures WIDTH-bit operands on a start strobe and presents one bit pair per cycle to the adder, LSB first.
- Recirculates the adder's carry through a flip-flop and assembles the serial sum into a parallel result.
- Sits between the parent that issues add requests and the `full_adder` instance; the parent wires the fa_* ports to that instance.

---
 rtl/serial_add_ctrl.sv | 153 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequencing controller for one external 1-bit full adder.
// Captures WIDTH-bit operands on start, feeds one bit pair per cycle
// (LSB first) to the adder, recirculates the carry through carry_q and
// assembles the serial sum into a registered parallel result.
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow
// output ovf, captured alongside sum_out.
module serial_add_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_out_q, sum_out_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Next-state logic: operand capture, bit-serial shifting and result capture.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // a missing default in always_comb infers a latch.
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    sum_sr_d  = sum_sr_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_out_d = sum_out_q;
    cout_d    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          carry_d = cin_in;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        if (cnt_q == CNT_LAST) begin
          // Last bit: the adder outputs of this cycle complete the result.
          sum_out_d = {fa_sum, sum_sr_q[WIDTH-1:1]};
          cout_d    = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
          // Carry into the MSB differing from carry out of it means the
          // signed result does not fit.
          ovf_d     = carry_q ^ fa_cout;
`endif
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset also aborts an add in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= ST_IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      sum_sr_q  <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum_out_q <= '0;
      cout_q    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      sum_sr_q  <= sum_sr_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      sum_out_q <= sum_out_d;
      cout_q    <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  // Adder drive is live only while shifting; quiet zeros otherwise.
  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (state_q == ST_SHIFT) begin
      fa_a   = a_sr_q[0];
      fa_b   = b_sr_q[0];
      fa_cin = carry_q;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign sum_out  = sum_out_q;
  assign cout_out = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: table-driven directed vectors, hand-written
// multi-cycle sequences (start while busy, mid-operation reset) and random
// adds compared against plain-arithmetic expectations. The external full
// adder is modelled behaviourally here.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         cin_in;
  logic         busy, done;
  logic [W-1:0] sum_out;
  logic         cout_out;
  logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // External 1-bit full adder.
  assign {fa_cout, fa_sum} = 2'(fa_a) + 2'(fa_b) + 2'(fa_cin);

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .busy     (busy),
    .done     (done),
    .sum_out  (sum_out),
    .cout_out (cout_out),
`ifdef SERIAL_ADD_OVF_EN
    .ovf      (ovf),
`endif
    .fa_a     (fa_a),
    .fa_b     (fa_b),
    .fa_cin   (fa_cin),
    .fa_sum   (fa_sum),
    .fa_cout  (fa_cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one add and follow it to completion, checking the serial drive,
  // latency, busy duration, result and the return to idle.
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W-1:0] exp_sum, input logic exp_cout,
                         input logic exp_ovf);
    int  busy_cnt;
    bit  got_done;
    start  = 1'b1;
    a_in   = a;
    b_in   = b;
    cin_in = cin;
    tick();
    start  = 1'b0;
    a_in   = W'($urandom);
    b_in   = W'($urandom);
    cin_in = 1'($urandom);
    busy_cnt = 0;
    got_done = 1'b0;
    for (int k = 1; k <= W + 4 && !got_done; k++) begin
      if (busy) busy_cnt++;
      if (k <= W) check("fa_ab_bit", {30'd0, fa_a, fa_b}, {30'd0, a[k-1], b[k-1]});
      if (k == 1) check("fa_cin_first", 32'(fa_cin), 32'(cin));
      if (done) begin
        got_done = 1'b1;
        check("done_latency", k, W + 1);
        check("sum_out", 32'(sum_out), 32'(exp_sum));
        check("cout_out", 32'(cout_out), 32'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", 32'(ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("unexpected unknown ovf expectation");
`endif
      end else begin
        tick();
        a_in = W'($urandom);
        b_in = W'($urandom);
      end
    end
    if (!got_done) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("busy_cycles", busy_cnt, W + 1);
      tick();
      check("idle_after_done", {30'd0, busy, done}, 32'd0);
      check("fa_idle", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
      check("sum_held", {23'd0, cout_out, sum_out}, {23'd0, exp_cout, exp_sum});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0]   ref_full;
    logic [W-1:0] ra, rb;
    logic         rc, rovf;
    int           done_cnt, busy_seen;

    tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
    tick();
    tick();
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_result", {23'd0, cout_out, sum_out}, 32'd0);
    check("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    // Idle with start low must stay idle.
    tick();
    tick();
    tick();
    check("idle_hold", {30'd0, busy, done}, 32'd0);

    // Directed table.
    for (int i = 0; i < 6; i++)
      run_add(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].exp_sum, tbl[i].exp_cout, tbl[i].exp_ovf);

    // Start re-pulsed during SHIFT cycle 3 and in the DONE cycle: ignored.
    start = 1'b1; a_in = 8'h12; b_in = 8'h34; cin_in = 1'b0;
    tick();                                   // cycle N+1
    start = 1'b0;
    tick();
    tick();                                   // cycle N+3
    start = 1'b1; a_in = 8'hAA; b_in = 8'h55;
    tick();                                   // cycle N+4
    start = 1'b0;
    done_cnt = 0;
    for (int k = 4; k <= 20 && done_cnt == 0; k++) begin
      if (done) begin
        done_cnt++;
        check("busy_start_latency", k, W + 1);
        check("busy_start_sum", 32'(sum_out), 32'h46);
      end else begin
        tick();
      end
    end
    if (done_cnt == 0) check("busy_start_timeout", 32'd0, 32'd1);
    start = 1'b1;                             // pulse during DONE
    tick();
    start = 1'b0;
    check("done_start_ignored", 32'(busy), 32'd0);
    busy_seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) done_cnt++;
      if (busy) busy_seen++;
      tick();
    end
    check("single_done_pulse", done_cnt, 1);
    check("no_second_op", busy_seen, 0);
    check("busy_start_sum_held", 32'(sum_out), 32'h46);

    // Reset during SHIFT cycle 4 aborts the add.
    start = 1'b1; a_in = 8'h5A; b_in = 8'h33; cin_in = 1'b0;
    tick();                                   // cycle N+1
    start = 1'b0;
    tick();
    tick();
    tick();                                   // cycle N+4
    check("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy_done", {30'd0, busy, done}, 32'd0);
    check("abort_result", {23'd0, cout_out, sum_out}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check("abort_ovf", 32'(ovf), 32'd0);
`endif
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) done_cnt++;
      tick();
    end
    check("abort_no_done", done_cnt, 0);
    run_add(8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0);

    // Random adds against plain unsigned arithmetic.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      ref_full = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
      rovf = (ra[W-1] == rb[W-1]) && (ref_full[W-1] != ra[W-1]);
      run_add(ra, rb, rc, ref_full[W-1:0], ref_full[W], rovf);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
